burst_read_gen: RTL and testbench

Synthesizable burst read-side traffic generator for the FIFO throughput bench: the consuming counterpart to the bench's write stimulus. It drains a FIFO read port in bursts of `BURST_SIZE` words separated by `IDLE_CYCLES` idle cycles, for `NUM_BURSTS` bursts. It checks every word against a fixed expected value and accumulates throughput and stall statistics, so buffer depth can be sized against a given write/read profile.

---
 rtl/burst_gen_pkg.sv | 23 ++
 rtl/burst_read_gen_if.sv | 15 +
 rtl/burst_read_gen_sat_counter.sv | 42 ++++
 rtl/burst_read_gen.sv | 140 ++++++++++++++
 tb/tb_burst_read_gen.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst traffic generators (read side today,
// write side planned).
//   gen_state_e    : FSM state encoding shared by both generators
//   MIN_BURST_SIZE : smallest legal burst length
//   MIN_CNT_W      : smallest legal statistics counter width
//   cnt_width()    : bits needed to hold 0..max_val (at least 1)
package burst_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    localparam int MIN_BURST_SIZE = 1;
    localparam int MIN_CNT_W      = 2;

    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/burst_read_gen_if.sv
// FIFO read port bundle.
//   rrdy  : FIFO not empty
//   rdata : FIFO head data (first-word-fall-through)
//   re    : read enable from the generator
// master = the read generator, slave = the FIFO side.
interface burst_read_gen_if #(
    parameter int DATA_W = 1
) ();
    logic              rrdy;
    logic [DATA_W-1:0] rdata;
    logic              re;

    modport master (input rrdy, input rdata, output re);
    modport slave  (output rrdy, output rdata, input re);
endinterface

// File: rtl/burst_read_gen_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   clr_i  : clear to zero (wins over inc_i)
//   inc_i  : increment by one, holding at all-ones
//   cnt_o  : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/burst_read_gen.sv
// Burst read-side traffic generator: drains a FIFO in bursts of BURST_SIZE
// words separated by IDLE_CYCLES idle cycles, for NUM_BURSTS bursts
// (0 = unlimited), checking every word against EXPECTED_DATA and
// collecting throughput/stall statistics.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   start_i  : single-cycle run request (honoured in IDLE/DONE only)
//   fifo     : FIFO read port (rrdy, rdata, re)
//   busy_o   : run in progress (BURST or GAP)
//   done_o   : run complete
//   err_o    : sticky data-mismatch flag
//   words_o  : words read this run (saturating)
//   stall_o  : BURST cycles with the FIFO empty (saturating)
//   bursts_o : bursts completed (saturating)
module burst_read_gen
    import burst_gen_pkg::*;
#(
    parameter int                DATA_W        = 1,
    parameter logic [DATA_W-1:0] EXPECTED_DATA = 1,
    parameter int                BURST_SIZE    = 10,
    parameter int                IDLE_CYCLES   = 10,
    parameter int                NUM_BURSTS    = 10,
    parameter int                CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    burst_read_gen_if.master fifo,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o,
    output logic [CNT_W-1:0] stall_o,
    output logic [CNT_W-1:0] bursts_o
);

    if (BURST_SIZE < MIN_BURST_SIZE) begin : g_chk_burst
        $error("burst_read_gen: BURST_SIZE must be >= 1");
    end
    if (CNT_W < MIN_CNT_W) begin : g_chk_cnt
        $error("burst_read_gen: CNT_W must be >= 2");
    end

    localparam int BCNT_W = cnt_width(BURST_SIZE - 1);
    localparam int GCNT_W = cnt_width((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    gen_state_e        state_q, state_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic [GCNT_W-1:0] gap_q, gap_d;
    logic              err_q, err_d;

    logic              xfer;
    logic              start_ok;
    logic              burst_end;
    logic              last_burst;
    logic              stall_inc;
    logic [CNT_W:0]    bursts_nxt;

    // Never read an empty FIFO: re is gated by rrdy in the same cycle.
    assign fifo.re   = (state_q == ST_BURST) & fifo.rrdy;
    assign xfer      = fifo.re;
    assign start_ok  = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign stall_inc = (state_q == ST_BURST) & ~fifo.rrdy;
    assign burst_end = xfer & (beat_q == BCNT_W'(BURST_SIZE - 1));

    // Compare one bit wider so a saturated bursts count cannot alias.
    assign bursts_nxt = {1'b0, bursts_o} + 1'b1;
    assign last_burst = (NUM_BURSTS != 0) && (bursts_nxt == (CNT_W+1)'(NUM_BURSTS));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    gap_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    err_d = err_q | (fifo.rdata != EXPECTED_DATA);
                    if (burst_end) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = ST_DONE;
                        end else if (IDLE_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GCNT_W'(IDLE_CYCLES - 1)) begin
                    state_d = ST_BURST;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_words (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(start_ok), .inc_i(xfer),      .cnt_o(words_o)
    );
    sat_counter #(.W(CNT_W)) u_stall (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(start_ok), .inc_i(stall_inc), .cnt_o(stall_o)
    );
    sat_counter #(.W(CNT_W)) u_bursts (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(start_ok), .inc_i(burst_end), .cnt_o(bursts_o)
    );

    assign busy_o = (state_q == ST_BURST) | (state_q == ST_GAP);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_burst_read_gen.sv
module tb_burst_read_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- DUT A: default parameters ----------------
    logic        rst_a_n, start_a;
    logic        busy_a, done_a, err_a;
    logic [15:0] words_a, stall_a, bursts_a;
    burst_read_gen_if #(.DATA_W(1)) if_a ();
    burst_read_gen #(
        .DATA_W(1), .EXPECTED_DATA(1'b1), .BURST_SIZE(10), .IDLE_CYCLES(10),
        .NUM_BURSTS(10), .CNT_W(16)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_a_n), .start_i(start_a), .fifo(if_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
        .words_o(words_a), .stall_o(stall_a), .bursts_o(bursts_a)
    );

    // ---------------- DUT B: BURST_SIZE=4, IDLE_CYCLES=0, NUM_BURSTS=2 ----------------
    logic        rst_b_n, start_b;
    logic        busy_b, done_b, err_b;
    logic [15:0] words_b, stall_b, bursts_b;
    burst_read_gen_if #(.DATA_W(1)) if_b ();
    burst_read_gen #(
        .DATA_W(1), .EXPECTED_DATA(1'b1), .BURST_SIZE(4), .IDLE_CYCLES(0),
        .NUM_BURSTS(2), .CNT_W(16)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_b_n), .start_i(start_b), .fifo(if_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .words_o(words_b), .stall_o(stall_b), .bursts_o(bursts_b)
    );

    // ---------------- DUT C: unlimited, CNT_W=4 ----------------
    logic        rst_c_n, start_c;
    logic        busy_c, done_c, err_c;
    logic [3:0]  words_c, stall_c, bursts_c;
    burst_read_gen_if #(.DATA_W(1)) if_c ();
    burst_read_gen #(
        .DATA_W(1), .EXPECTED_DATA(1'b1), .BURST_SIZE(10), .IDLE_CYCLES(10),
        .NUM_BURSTS(0), .CNT_W(4)
    ) u_c (
        .clk_i(clk), .rst_ni(rst_c_n), .start_i(start_c), .fifo(if_c),
        .busy_o(busy_c), .done_o(done_c), .err_o(err_c),
        .words_o(words_c), .stall_o(stall_c), .bursts_o(bursts_c)
    );

    typedef struct {
        bit start;
        bit rrdy;
        bit rdata;
        bit re;
        bit busy;
        bit done;
        bit err;
        int words;
        int stall;
        int bursts;
    } vec_t;

    vec_t vt[17];
    vec_t sb_b[$];
    bit   sb_re[$];

    // Start pulse then 190 cycles of the 10-on/10-off pattern, ending in DONE.
    task automatic run_a_full();
        bit e;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("a_busy_start", int'(busy_a), 1);
        for (int i = 1; i <= 190; i++) begin
            @(negedge clk);
            sb_re.push_back(((i - 1) % 20) < 10);
            #1;
            e = sb_re.pop_front();
            chk("a_re_pattern", int'(if_a.re), int'(e));
            @(posedge clk); #1;
            if (i < 190) chk("a_busy_run", int'(busy_a), 1);
        end
        chk("a_done", int'(done_a), 1);
        chk("a_busy_end", int'(busy_a), 0);
        chk("a_words", int'(words_a), 100);
        chk("a_stall", int'(stall_a), 0);
        chk("a_bursts", int'(bursts_a), 10);
        chk("a_err", int'(err_a), 0);
        @(negedge clk); #1;
        chk("a_re_in_done", int'(if_a.re), 0);
    endtask

    initial begin
        vec_t e;
        bit   exp_re;
        int   exp_w, exp_bu;

        //               st rr rd re bu dn er  w  s  b
        vt[0]  = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        vt[2]  = '{0, 1, 1, 1, 1, 0, 0, 2, 0, 0};
        vt[3]  = '{0, 0, 1, 0, 1, 0, 0, 2, 1, 0};
        vt[4]  = '{0, 0, 0, 0, 1, 0, 0, 2, 2, 0};  // bad data without transfer
        vt[5]  = '{1, 0, 1, 0, 1, 0, 0, 2, 3, 0};  // start while busy: ignored
        vt[6]  = '{0, 1, 1, 1, 1, 0, 0, 3, 3, 0};
        vt[7]  = '{0, 1, 1, 1, 1, 0, 0, 4, 3, 1};  // burst 1 done, no gap
        vt[8]  = '{0, 1, 0, 1, 1, 0, 1, 5, 3, 1};  // 5th transfer is bad
        vt[9]  = '{0, 1, 1, 1, 1, 0, 1, 6, 3, 1};
        vt[10] = '{0, 1, 1, 1, 1, 0, 1, 7, 3, 1};
        vt[11] = '{0, 1, 1, 1, 0, 1, 1, 8, 3, 2};  // last transfer -> DONE
        vt[12] = '{0, 1, 1, 0, 0, 1, 1, 8, 3, 2};
        vt[13] = '{0, 0, 0, 0, 0, 1, 1, 8, 3, 2};  // empty in DONE is no stall
        vt[14] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};  // restart clears all
        vt[15] = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        vt[16] = '{0, 1, 1, 1, 1, 0, 0, 2, 0, 0};

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        if_a.rrdy = 1'b1; if_a.rdata = 1'b1;
        if_b.rrdy = 1'b0; if_b.rdata = 1'b1;
        if_c.rrdy = 1'b1; if_c.rdata = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_re", int'(if_a.re), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_words", int'(words_a), 0);
        chk("rst_stall", int'(stall_a), 0);
        chk("rst_bursts", int'(bursts_a), 0);
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

        // Default full run
        run_a_full();

        // Reset in the middle of the 3rd burst
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            sb_re.push_back(((i - 1) % 20) < 10);
            #1;
            exp_re = sb_re.pop_front();
            chk("a2_re_pattern", int'(if_a.re), int'(exp_re));
            @(posedge clk); #1;
        end
        chk("a2_bursts_pre", int'(bursts_a), 2);
        chk("a2_words_pre", int'(words_a), 25);
        @(negedge clk);
        rst_a_n = 1'b0;
        @(posedge clk); #1;
        chk("a2_rst_re", int'(if_a.re), 0);
        chk("a2_rst_busy", int'(busy_a), 0);
        chk("a2_rst_done", int'(done_a), 0);
        chk("a2_rst_words", int'(words_a), 0);
        chk("a2_rst_stall", int'(stall_a), 0);
        chk("a2_rst_bursts", int'(bursts_a), 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        chk("a2_idle_re", int'(if_a.re), 0);
        run_a_full();

        // Table-driven run on DUT B
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start_b     = vt[i].start;
            if_b.rrdy   = vt[i].rrdy;
            if_b.rdata  = vt[i].rdata;
            sb_b.push_back(vt[i]);
            #1;
            chk($sformatf("b%0d_re", i), int'(if_b.re), int'(vt[i].re));
            @(posedge clk); #1;
            e = sb_b.pop_front();
            chk($sformatf("b%0d_busy", i), int'(busy_b), int'(e.busy));
            chk($sformatf("b%0d_done", i), int'(done_b), int'(e.done));
            chk($sformatf("b%0d_err", i), int'(err_b), int'(e.err));
            chk($sformatf("b%0d_words", i), int'(words_b), e.words);
            chk($sformatf("b%0d_stall", i), int'(stall_b), e.stall);
            chk($sformatf("b%0d_bursts", i), int'(bursts_b), e.bursts);
        end
        @(negedge clk);
        start_b = 1'b0;

        // Unlimited mode with 4-bit counters
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        exp_w  = 0;
        exp_bu = 0;
        for (int i = 1; i <= 340; i++) begin
            @(negedge clk);
            start_c = (i == 100) || (i == 105);
            exp_re = ((i - 1) % 20) < 10;
            #1;
            chk("c_re", int'(if_c.re), int'(exp_re));
            if (exp_re && exp_w < 15) exp_w++;
            if (((i - 1) % 20) == 9 && exp_bu < 15) exp_bu++;
            @(posedge clk); #1;
            start_c = 1'b0;
            chk("c_words", int'(words_c), exp_w);
            chk("c_bursts", int'(bursts_c), exp_bu);
            chk("c_done", int'(done_c), 0);
            chk("c_busy", int'(busy_c), 1);
        end
        chk("c_stall", int'(stall_c), 0);
        chk("c_err", int'(err_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
